quant_child: RTL and testbench
==============================

Name: quant_child

Overview:
- Per-column requantization stage sitting directly downstream of bias_child.
- Consumes the 32-bit biased accumulator stream (data + valid) and applies a fixed-point scale, a round-half-up right shift and a zero-point offset.
- Saturates each result to int8 and packs four results into one 32-bit word for the output writeback path.
- Three-stage arithmetic pipeline plus a packer with flush support.

Parameters:
- IN_W, 32, width of the biased input data (signed).
- MULT_W, 16, width of the signed scale multiplier.
- SHIFT_W, 5, width of the right-shift amount (0..31).
- OUT_W, 8, width of each quantized lane (signed).
- PACK, 4, lanes per output word; the output word is PACK*OUT_W bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  one-cycle pulse; samples the cfg_* inputs.
- cfg_mult  in  MULT_W  signed scale.
- cfg_shift  in  SHIFT_W  unsigned right shift.
- cfg_zero_point  in  OUT_W  signed output zero point.
- bias_z_data_in  in  IN_W  signed biased data from bias_child.
- bias_z_valid_in  in  1  input qualifier.
- flush  in  1  one-cycle pulse; emits any partially filled word.
- q_data_out  out  PACK*OUT_W  packed word; lane 0 occupies bits [7:0].
- q_valid_out  out  1  one-cycle strobe for q_data_out.
- q_lanes_out  out  3  number of valid lanes in q_data_out (1..4).
- busy  out  1  any pipeline stage valid, or packer lane count nonzero.
- sat_count  out  16  number of saturated results; sticks at 0xFFFF.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0 and all stage valids clear.
  - Packer lane count goes to 0; pending partial data is discarded and never emitted.
  - Config resets to identity: mult=1, shift=0, zp=0.
- No backpressure. One input is accepted per cycle whenever bias_z_valid_in=1.
- Config load:
  - cfg_load is honoured only when busy=0 and bias_z_valid_in=0 in the same cycle; otherwise it is silently ignored.
  - A honoured load applies to every input accepted from the next cycle onward.
- S1 (input cycle N, registered at N+1): prod = data * mult, 48-bit signed, full precision.
- S2 (N+2):
  - If shift>0: r = (prod + 2^(shift-1)) >>> shift. If shift=0: r = prod.
  - Then r = r + sign-extended zp. Width is 49 bits, so there is no overflow.
- S3 (N+3):
  - Clamp r to [-128, 127]. A saturation event is counted whenever clamping changes the value.
  - The clamped byte is written into packer lane idx, then idx increments.
- Packer:
  - When the fourth lane is written (idx 3→0), at N+4 the full word is presented: q_valid_out=1, q_lanes_out=4.
  - q_valid_out is high for exactly one cycle; q_data_out holds its value until the next strobe.
- Flush:
  - The flush pulse travels the pipeline as a marker alongside valid, so it is ordered after all earlier data.
  - flush and bias_z_valid_in in the same cycle: the data is processed first, then the flush.
  - When the marker reaches the packer with idx>0: emit the partial word with unused lanes zeroed, q_lanes_out=idx, then reset idx to 0.
  - With idx=0: no output.
  - When the marker arrives on the same cycle as a fourth-lane completion: the full word is emitted and the flush produces nothing further.
- sat_count increments by 1 per saturated result and holds at 0xFFFF.
- busy is combinational from the stage valids and idx.

Optional Feature:
- Macro QUANT_RELU_EN.
- Defined: the lower clamp bound becomes zp instead of -128, giving quantized-domain ReLU. Results below zp output zp. This counts as saturation only if r < -128.
- Undefined: lower clamp bound is -128.
- Latency and ports are identical in both builds.

Decomposition:
- Package quant_pkg holds:
  - width constants: IN_W, MULT_W, SHIFT_W, OUT_W, PACK, PROD_W=48;
  - identity config constants: MULT_ONE=1, SHIFT_ZERO=0, ZP_ZERO=0;
  - clamp bounds Q_MIN=-128, Q_MAX=127;
  - a typedef for the packed output word.
- One sub-module, quant_packer, contains the lane index, byte assembly, flush handling and output strobe. quant_child holds config and the S1–S3 arithmetic.

Test Plan:
- Identity config after reset; inputs 1,2,3,4 on consecutive cycles -> 4 cycles after the last input: q_data_out=0x04030201, q_lanes_out=4, one-cycle q_valid_out.
- cfg mult=3, shift=2, zp=5; inputs 10, -10, 0, 2 -> bytes 13, -2(0xFE), 5, 7 -> word 0x0705FE0D.
- Identity config; inputs 1000, -1000, 127, -128 -> word 0x807F807F, sat_count=2.
- Inputs 7, -1, then flush -> q_data_out=0x0000FF07, q_lanes_out=2. A second flush produces no output.
- cfg_load with mult=5 while busy=1 -> ignored; following data is still scaled by 1.
- rst driven low asynchronously with 3 lanes pending -> outputs 0 immediately. After release, busy=0 and no partial word is emitted.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared widths, identity configuration and clamp bounds for the requantization stage.
package quant_pkg;

  localparam int IN_W    = 32;
  localparam int MULT_W  = 16;
  localparam int SHIFT_W = 5;
  localparam int OUT_W   = 8;
  localparam int PACK    = 4;
  localparam int PROD_W  = 48;
  localparam int R_W     = PROD_W + 1;

  localparam logic signed [MULT_W-1:0] MULT_ONE   = MULT_W'(1);
  localparam logic [SHIFT_W-1:0]       SHIFT_ZERO = '0;
  localparam logic signed [OUT_W-1:0]  ZP_ZERO    = '0;

  localparam int Q_MIN = -128;
  localparam int Q_MAX = 127;

  typedef logic [PACK*OUT_W-1:0] q_word_t;

endpackage

// File: rtl/quant_packer.sv
// Collects int8 lanes into a packed word; emits on the fourth lane or on an in-band flush marker.
module quant_packer
  import quant_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             lane_valid,
  input  logic [OUT_W-1:0] lane_byte,
  input  logic             lane_flush,
  output q_word_t          word,
  output logic             strobe,
  output logic [2:0]       lanes,
  output logic             pending
);

  logic [PACK-1:0][OUT_W-1:0] lane_q;
  logic [PACK-1:0][OUT_W-1:0] lane_next;
  logic [PACK-1:0][OUT_W-1:0] word_lanes;
  logic [1:0]                 idx_q;
  logic [2:0]                 fill;
  logic                       emit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lane_next = lane_q;
    if (lane_valid) lane_next[idx_q] = lane_byte;
    fill = {1'b0, idx_q} + {2'b00, lane_valid};
    emit = (fill == 3'(PACK)) || (lane_flush && (fill != 3'd0));
    word_lanes = '0;
    for (int i = 0; i < PACK; i++) begin
      if (3'(i) < fill) word_lanes[i] = lane_next[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      word   <= '0;
      strobe <= 1'b0;
      lanes  <= '0;
    end else begin
      strobe <= emit;
      if (emit) begin
        word  <= q_word_t'(word_lanes);
        lanes <= fill;
        idx_q <= '0;
      end else begin
        idx_q <= fill[1:0];
      end
    end
  end

  // NOTE: the lane buffer is left unreset; lanes at or above the fill count are masked on emit.
  always_ff @(posedge clk) begin
    lane_q <= lane_next;
  end

  assign pending = (idx_q != 2'd0);

endmodule

// File: rtl/quant_child.sv
// Requantization: scale, round-half-up shift, zero point, int8 saturation, 4-lane packing.
// Optional build macro QUANT_RELU_EN raises the lower clamp bound to the zero point.
module quant_child
  import quant_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [MULT_W-1:0]    cfg_mult,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  input  logic [OUT_W-1:0]     cfg_zero_point,
  input  logic [IN_W-1:0]      bias_z_data_in,
  input  logic                 bias_z_valid_in,
  input  logic                 flush,
  output logic [PACK*OUT_W-1:0] q_data_out,
  output logic                 q_valid_out,
  output logic [2:0]           q_lanes_out,
  output logic                 busy,
  output logic [15:0]          sat_count
);

  localparam logic signed [R_W-1:0] HI_BOUND  = R_W'(Q_MAX);
  localparam logic signed [R_W-1:0] MIN_BOUND = R_W'(Q_MIN);

  logic signed [MULT_W-1:0]  mult_q;
  logic [SHIFT_W-1:0]        shift_q;
  logic signed [OUT_W-1:0]   zp_q;

  logic signed [IN_W-1:0]    data_s;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [R_W-1:0]     rnd_c;
  logic signed [R_W-1:0]     r_c;
  logic signed [R_W-1:0]     lo_c;
  logic [OUT_W-1:0]          byte_c;
  logic                      sat_c;

  logic                      s1_valid, s2_valid, s3_valid;
  logic                      s1_flush, s2_flush, s3_flush;
  logic signed [PROD_W-1:0]  s1_prod;
  logic signed [R_W-1:0]     s2_r;
  logic [OUT_W-1:0]          s3_byte;
  logic                      pending;
  logic                      cfg_take;

  assign data_s   = bias_z_data_in;
  assign cfg_take = cfg_load && !busy && !bias_z_valid_in;
  assign busy     = s1_valid || s2_valid || s3_valid || pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mult_q  <= MULT_ONE;
      shift_q <= SHIFT_ZERO;
      zp_q    <= ZP_ZERO;
    end else if (cfg_take) begin
      mult_q  <= cfg_mult;
      shift_q <= cfg_shift;
      zp_q    <= cfg_zero_point;
    end
  end

  // Config is only reloaded with the pipeline empty, so later stages read it directly.
  always_comb begin
    prod_c = PROD_W'(data_s) * PROD_W'(mult_q);
    rnd_c  = '0;
    if (shift_q != SHIFT_ZERO) rnd_c[shift_q - 1'b1] = 1'b1;
    r_c = ((R_W'(s1_prod) + rnd_c) >>> shift_q) + R_W'(zp_q);
  end

  always_comb begin
`ifdef QUANT_RELU_EN
    lo_c = R_W'(zp_q);
`else
    lo_c = MIN_BOUND;
`endif
    sat_c = (s2_r > HI_BOUND) || (s2_r < MIN_BOUND);
    if (s2_r > HI_BOUND)  byte_c = OUT_W'(Q_MAX);
    else if (s2_r < lo_c) byte_c = lo_c[OUT_W-1:0];
    else                  byte_c = s2_r[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s1_flush  <= 1'b0;
      s2_flush  <= 1'b0;
      s3_flush  <= 1'b0;
      s1_prod   <= '0;
      s2_r      <= '0;
      s3_byte   <= '0;
      sat_count <= '0;
    end else begin
      s1_valid <= bias_z_valid_in;
      s1_flush <= flush;
      s2_valid <= s1_valid;
      s2_flush <= s1_flush;
      s3_valid <= s2_valid;
      s3_flush <= s2_flush;
      if (bias_z_valid_in) s1_prod <= prod_c;
      if (s1_valid)        s2_r    <= r_c;
      if (s2_valid)        s3_byte <= byte_c;
      if (s2_valid && sat_c && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
    end
  end

  quant_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .lane_valid (s3_valid),
    .lane_byte  (s3_byte),
    .lane_flush (s3_flush),
    .word       (q_data_out),
    .strobe     (q_valid_out),
    .lanes      (q_lanes_out),
    .pending    (pending)
  );

endmodule

// File: tb/tb_quant_child.sv
// Directed self-checking bench for quant_child; expectations follow QUANT_RELU_EN when defined.
module tb_quant_child;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_load = 1'b0;
  logic [15:0] cfg_mult = '0;
  logic [4:0]  cfg_shift = '0;
  logic [7:0]  cfg_zero_point = '0;
  logic [31:0] bias_z_data_in = '0;
  logic        bias_z_valid_in = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] q_data_out;
  logic        q_valid_out;
  logic [2:0]  q_lanes_out;
  logic        busy;
  logic [15:0] sat_count;

  int checks = 0;
  int failures = 0;
  int lat;

`ifdef QUANT_RELU_EN
  localparam logic [31:0] EXP_SAT   = 32'h007F007F;
  localparam logic [31:0] EXP_FLUSH = 32'h00000007;
  localparam logic [31:0] EXP_CFG   = 32'h07050505;
  localparam logic [31:0] EXP_RND   = 32'h00010002;
`else
  localparam logic [31:0] EXP_SAT   = 32'h807F807F;
  localparam logic [31:0] EXP_FLUSH = 32'h0000FF07;
  localparam logic [31:0] EXP_CFG   = 32'h0705FE0D;
  localparam logic [31:0] EXP_RND   = 32'h0001FF02;
`endif

  quant_child dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_load        (cfg_load),
    .cfg_mult        (cfg_mult),
    .cfg_shift       (cfg_shift),
    .cfg_zero_point  (cfg_zero_point),
    .bias_z_data_in  (bias_z_data_in),
    .bias_z_valid_in (bias_z_valid_in),
    .flush           (flush),
    .q_data_out      (q_data_out),
    .q_valid_out     (q_valid_out),
    .q_lanes_out     (q_lanes_out),
    .busy            (busy),
    .sat_count       (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic f);
    bias_z_data_in  = d;
    bias_z_valid_in = 1'b1;
    flush           = f;
    tick();
    bias_z_valid_in = 1'b0;
    flush           = 1'b0;
    bias_z_data_in  = '0;
  endtask

  task automatic load_cfg(input logic [15:0] m, input logic [4:0] s, input logic [7:0] z);
    cfg_mult       = m;
    cfg_shift      = s;
    cfg_zero_point = z;
    cfg_load       = 1'b1;
    tick();
    cfg_load       = 1'b0;
  endtask

  task automatic wait_word(input string tag, input logic [31:0] exp_data,
                           input logic [2:0] exp_lanes, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 12) begin
      tick();
      n++;
      if (q_valid_out) seen = 1'b1;
    end
    check({tag, " strobe"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " data"}, q_data_out, exp_data);
      check({tag, " lanes"}, 32'(q_lanes_out), 32'(exp_lanes));
      tick();
      check({tag, " one-cycle"}, 32'(q_valid_out), 32'd0);
    end
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick();
      if (q_valid_out) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst = 1'b1;
    tick();

    check("reset data", q_data_out, 32'h0);
    check("reset valid", 32'(q_valid_out), 32'd0);
    check("reset lanes", 32'(q_lanes_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset sat", 32'(sat_count), 32'd0);

    // Identity config: 1,2,3,4 packs little-lane-first.
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    push(32'd3, 1'b0);
    push(32'd4, 1'b0);
    wait_word("ident", 32'h04030201, 3'd4, lat);
    check("ident latency", 32'(lat), 32'd3);
    check("ident idle busy", 32'(busy), 32'd0);

    // Saturation at both ends plus exact bounds.
    push(32'd1000, 1'b0);
    push(-32'sd1000, 1'b0);
    push(32'd127, 1'b0);
    push(-32'sd128, 1'b0);
    wait_word("sat", EXP_SAT, 3'd4, lat);
    check("sat count", 32'(sat_count), 32'd2);

    // Partial word: flush on the same cycle as the second datum.
    push(32'd7, 1'b0);
    push(-32'sd1, 1'b1);
    wait_word("flush", EXP_FLUSH, 3'd2, lat);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_quiet("flush empty quiet", 8);
    check("flush hold data", q_data_out, EXP_FLUSH);

    // Flush coinciding with the fourth lane yields only the full word.
    push(32'd5, 1'b0);
    push(32'd6, 1'b0);
    push(32'd7, 1'b0);
    push(32'd8, 1'b1);
    wait_word("full+flush", 32'h08070605, 3'd4, lat);
    expect_quiet("full+flush quiet", 6);

    // cfg_load while busy, and while data is valid, must be ignored.
    push(32'd9, 1'b0);
    load_cfg(16'd5, 5'd0, 8'd0);
    push(32'd1, 1'b0);
    push(32'd1, 1'b0);
    push(32'd1, 1'b0);
    wait_word("cfg busy", 32'h01010109, 3'd4, lat);
    cfg_mult  = 16'd5;
    cfg_load  = 1'b1;
    push(32'd2, 1'b0);
    cfg_load  = 1'b0;
    push(32'd3, 1'b0);
    push(32'd4, 1'b0);
    push(32'd5, 1'b0);
    wait_word("cfg valid", 32'h05040302, 3'd4, lat);

    // mult=3, shift=2, zp=5.
    load_cfg(16'd3, 5'd2, 8'd5);
    push(32'd10, 1'b0);
    push(-32'sd10, 1'b0);
    push(32'd0, 1'b0);
    push(32'd2, 1'b0);
    wait_word("cfg325", EXP_CFG, 3'd4, lat);

    // Round-half-up at shift=1 on both signs.
    load_cfg(16'd1, 5'd1, 8'd0);
    push(32'd3, 1'b0);
    push(-32'sd3, 1'b0);
    push(32'd1, 1'b0);
    push(-32'sd1, 1'b0);
    wait_word("round", EXP_RND, 3'd4, lat);
    check("pre-reset sat", 32'(sat_count), 32'd2);

    // Async reset with three lanes pending.
    push(32'd11, 1'b0);
    push(32'd12, 1'b0);
    push(32'd13, 1'b0);
    repeat (3) tick();
    check("pending busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async data", q_data_out, 32'h0);
    check("async lanes", 32'(q_lanes_out), 32'd0);
    check("async sat", 32'(sat_count), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post-reset busy", 32'(busy), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_quiet("post-reset quiet", 8);

    // Config must be back to identity.
    push(32'd5, 1'b0);
    push(32'd6, 1'b0);
    push(32'd7, 1'b0);
    push(32'd8, 1'b0);
    wait_word("post-reset ident", 32'h08070605, 3'd4, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
